// File: rtl/memc3_mem_clear_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : memc3_mem_clear_sequencer
// Brief    : Clears a DDR region through one MCB write port after PLL lock and
//            calibration, then raises mem_ready.
// Revision : 1.0 - initial release
// ============================================================================
module memc3_mem_clear_sequencer #(
    parameter int          DATA_WIDTH    = 32,
    parameter int          BURST_LEN     = 32,
    parameter logic [29:0] CLEAR_BASE    = 30'h0,
    parameter int          CLEAR_WORDS   = 1024,
    parameter int          SETTLE_CYCLES = 16,
    parameter logic [31:0] FILL_PATTERN  = 32'h0000_0000
) (
    input  logic                    clk0,
    input  logic                    sys_rst_n,
    input  logic                    pll_lock,
    input  logic                    calib_done,
    input  logic                    start,
    output logic                    cmd_en,
    output logic [2:0]              cmd_instr,
    output logic [5:0]              cmd_bl,
    output logic [29:0]             cmd_byte_addr,
    input  logic                    cmd_full,
    output logic                    wr_en,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH/8-1:0] wr_mask,
    input  logic                    wr_full,
    input  logic                    wr_underrun,
    input  logic                    wr_error,
    output logic                    busy,
    output logic                    mem_ready,
    output logic                    error
);

    localparam int c_BURSTS = CLEAR_WORDS / BURST_LEN;
    localparam int c_REM_W  = $clog2(c_BURSTS + 1);
    localparam int c_SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [c_SET_W-1:0]    c_SETTLE_LAST = c_SET_W'(SETTLE_CYCLES - 1);
    localparam logic [6:0]            c_BURST_LAST  = 7'(BURST_LEN - 1);
    localparam logic [c_REM_W-1:0]    c_BURSTS_V    = c_REM_W'(c_BURSTS);
    localparam logic [29:0]           c_BURST_BYTES = 30'(BURST_LEN * 4);
    localparam logic [DATA_WIDTH-1:0] c_FILL        = DATA_WIDTH'(FILL_PATTERN);

    typedef enum logic [2:0] {
        S_WAIT_CAL = 3'd0,
        S_SETTLE   = 3'd1,
        S_FILL     = 3'd2,
        S_CMD      = 3'd3,
        S_DONE     = 3'd4,
        S_ERROR    = 3'd5
    } state_t;

    state_t               r_state,      w_state_nxt;
    logic [c_SET_W-1:0]   r_settle_cnt, w_settle_cnt_nxt;
    logic [6:0]           r_word_cnt,   w_word_cnt_nxt;
    logic [c_REM_W-1:0]   r_remaining,  w_remaining_nxt;
    logic [29:0]          r_addr,       w_addr_nxt;
    logic [29:0]          r_cmd_addr,   w_cmd_addr_nxt;
    logic                 r_cmd_en,     w_cmd_en_nxt;
    logic                 r_wr_en,      w_wr_en_nxt;
    logic                 r_busy,       w_busy_nxt;
    logic                 r_mem_ready,  w_mem_ready_nxt;
    logic                 r_error,      w_error_nxt;

    logic                 w_cal_ok;
    logic                 w_wr_fault;

    assign w_cal_ok   = pll_lock & calib_done;
    assign w_wr_fault = wr_error | wr_underrun;

    always_ff @(posedge clk0 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state      <= S_WAIT_CAL;
            r_settle_cnt <= '0;
            r_word_cnt   <= '0;
            r_remaining  <= '0;
            r_addr       <= CLEAR_BASE;
            r_cmd_addr   <= CLEAR_BASE;
            r_cmd_en     <= 1'b0;
            r_wr_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_mem_ready  <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_word_cnt   <= w_word_cnt_nxt;
            r_remaining  <= w_remaining_nxt;
            r_addr       <= w_addr_nxt;
            r_cmd_addr   <= w_cmd_addr_nxt;
            r_cmd_en     <= w_cmd_en_nxt;
            r_wr_en      <= w_wr_en_nxt;
            r_busy       <= w_busy_nxt;
            r_mem_ready  <= w_mem_ready_nxt;
            r_error      <= w_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_settle_cnt_nxt = r_settle_cnt;
        w_word_cnt_nxt   = r_word_cnt;
        w_remaining_nxt  = r_remaining;
        w_addr_nxt       = r_addr;
        w_cmd_addr_nxt   = r_cmd_addr;
        w_cmd_en_nxt     = 1'b0;
        w_wr_en_nxt      = 1'b0;
        w_busy_nxt       = r_busy;
        w_mem_ready_nxt  = r_mem_ready;
        w_error_nxt      = r_error;

        case (r_state)
            S_WAIT_CAL: begin
                w_settle_cnt_nxt = '0;
                if (w_cal_ok) begin
                    w_state_nxt = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (r_settle_cnt == c_SETTLE_LAST) begin
                    w_state_nxt      = S_FILL;
                    w_busy_nxt       = 1'b1;
                    w_addr_nxt       = CLEAR_BASE;
                    w_remaining_nxt  = c_BURSTS_V;
                    w_word_cnt_nxt   = '0;
                    w_settle_cnt_nxt = '0;
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt + c_SET_W'(1);
                end
            end

            S_FILL: begin
                // The word count leaves FILL on the last push, so a burst can never overfill.
                if (!wr_full) begin
                    w_wr_en_nxt    = 1'b1;
                    w_word_cnt_nxt = r_word_cnt + 7'd1;
                    if (r_word_cnt == c_BURST_LAST) begin
                        w_state_nxt = S_CMD;
                    end
                end
            end

            S_CMD: begin
                if (!cmd_full) begin
                    w_cmd_en_nxt    = 1'b1;
                    w_cmd_addr_nxt  = r_addr;
                    w_addr_nxt      = r_addr + c_BURST_BYTES;
                    w_remaining_nxt = r_remaining - c_REM_W'(1);
                    w_word_cnt_nxt  = '0;
                    if (r_remaining == c_REM_W'(1)) begin
                        w_state_nxt     = S_DONE;
                        w_busy_nxt      = 1'b0;
                        w_mem_ready_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_FILL;
                    end
                end
            end

            S_DONE: begin
                if (start) begin
                    w_state_nxt     = S_FILL;
                    w_mem_ready_nxt = 1'b0;
                    w_busy_nxt      = 1'b1;
                    w_addr_nxt      = CLEAR_BASE;
                    w_remaining_nxt = c_BURSTS_V;
                    w_word_cnt_nxt  = '0;
                end
            end

            S_ERROR: begin
                // Restart only once the memory is usable again; otherwise stay latched.
                if (start && w_cal_ok) begin
                    w_state_nxt     = S_FILL;
                    w_error_nxt     = 1'b0;
                    w_mem_ready_nxt = 1'b0;
                    w_busy_nxt      = 1'b1;
                    w_addr_nxt      = CLEAR_BASE;
                    w_remaining_nxt = c_BURSTS_V;
                    w_word_cnt_nxt  = '0;
                end
            end

            default: begin
                w_state_nxt = S_WAIT_CAL;
            end
        endcase

        if (((r_state == S_FILL) || (r_state == S_CMD)) && w_wr_fault) begin
            w_state_nxt     = S_ERROR;
            w_error_nxt     = 1'b1;
            w_busy_nxt      = 1'b0;
            w_mem_ready_nxt = 1'b0;
            w_cmd_en_nxt    = 1'b0;
            w_wr_en_nxt     = 1'b0;
        end

        // Losing lock or calibration outranks everything; any queued partial burst is abandoned.
        if ((r_state != S_WAIT_CAL) && (r_state != S_ERROR) && !w_cal_ok) begin
            w_state_nxt      = S_WAIT_CAL;
            w_mem_ready_nxt  = 1'b0;
            w_busy_nxt       = 1'b0;
            w_cmd_en_nxt     = 1'b0;
            w_wr_en_nxt      = 1'b0;
            w_addr_nxt       = CLEAR_BASE;
            w_settle_cnt_nxt = '0;
            w_word_cnt_nxt   = '0;
            w_remaining_nxt  = '0;
        end
    end

    assign cmd_en        = r_cmd_en;
    assign cmd_instr     = 3'b000;
    assign cmd_bl        = 6'(BURST_LEN - 1);
    assign cmd_byte_addr = r_cmd_addr;
    assign wr_en         = r_wr_en;
    assign wr_data       = c_FILL;
    assign wr_mask       = '0;
    assign busy          = r_busy;
    assign mem_ready     = r_mem_ready;
    assign error         = r_error;

endmodule
`default_nettype wire

// File: tb/tb_memc3_mem_clear_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_memc3_mem_clear_sequencer
// Brief    : Directed self-checking bench for the memory clear sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memc3_mem_clear_sequencer;

    logic        clk0 = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        pll_lock = 1'b1;
    logic        calib_done = 1'b0;
    logic        start = 1'b0;
    logic        cmd_full = 1'b0;
    logic        wr_full = 1'b0;
    logic        wr_underrun = 1'b0;
    logic        wr_error = 1'b0;

    logic        cmd_en, wr_en, busy, mem_ready, error;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;

    logic        b_cmd_en, b_wr_en, b_busy, b_mem_ready, b_error;
    logic [2:0]  b_cmd_instr;
    logic [5:0]  b_cmd_bl;
    logic [29:0] b_cmd_byte_addr;
    logic [31:0] b_wr_data;
    logic [3:0]  b_wr_mask;

    int checks = 0;
    int fails  = 0;

    always #5 clk0 = ~clk0;

    memc3_mem_clear_sequencer #(
        .DATA_WIDTH(32), .BURST_LEN(32), .CLEAR_BASE(30'h0), .CLEAR_WORDS(64),
        .SETTLE_CYCLES(16), .FILL_PATTERN(32'h0000_0000)
    ) dut (
        .clk0(clk0), .sys_rst_n(sys_rst_n), .pll_lock(pll_lock), .calib_done(calib_done),
        .start(start), .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
        .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full), .wr_en(wr_en),
        .wr_data(wr_data), .wr_mask(wr_mask), .wr_full(wr_full),
        .wr_underrun(wr_underrun), .wr_error(wr_error), .busy(busy),
        .mem_ready(mem_ready), .error(error)
    );

    memc3_mem_clear_sequencer #(
        .DATA_WIDTH(32), .BURST_LEN(32), .CLEAR_BASE(30'h1000), .CLEAR_WORDS(64),
        .SETTLE_CYCLES(16), .FILL_PATTERN(32'hA5A5_5A5A)
    ) dut_b (
        .clk0(clk0), .sys_rst_n(sys_rst_n), .pll_lock(pll_lock), .calib_done(calib_done),
        .start(start), .cmd_en(b_cmd_en), .cmd_instr(b_cmd_instr), .cmd_bl(b_cmd_bl),
        .cmd_byte_addr(b_cmd_byte_addr), .cmd_full(cmd_full), .wr_en(b_wr_en),
        .wr_data(b_wr_data), .wr_mask(b_wr_mask), .wr_full(wr_full),
        .wr_underrun(wr_underrun), .wr_error(wr_error), .busy(b_busy),
        .mem_ready(b_mem_ready), .error(b_error)
    );

    // Bus monitor: running totals only ever grow; tests work on deltas.
    int          wr_total = 0, b_wr_total = 0;
    int          data_bad = 0, b_data_bad = 0, mask_bad = 0, cmd_bad = 0;
    int          wrfull_viol = 0, cmdfull_viol = 0;
    logic [29:0] cmd_addr_q[$];
    int          cmd_wr_q[$];
    logic [29:0] b_cmd_addr_q[$];
    logic        wf_edge = 1'b0, cf_edge = 1'b0;

    always @(posedge clk0) begin
        wf_edge <= wr_full;
        cf_edge <= cmd_full;
    end

    always @(negedge clk0) begin
        if (wr_en === 1'b1) begin
            wr_total++;
            if (wr_data !== 32'h0000_0000) data_bad++;
            if (wr_mask !== 4'h0) mask_bad++;
            if (wf_edge) wrfull_viol++;
        end
        if (cmd_en === 1'b1) begin
            cmd_addr_q.push_back(cmd_byte_addr);
            cmd_wr_q.push_back(wr_total);
            if (cmd_bl !== 6'd31 || cmd_instr !== 3'b000) cmd_bad++;
            if (cf_edge) cmdfull_viol++;
        end
        if (b_wr_en === 1'b1) begin
            b_wr_total++;
            if (b_wr_data !== 32'hA5A5_5A5A) b_data_bad++;
        end
        if (b_cmd_en === 1'b1) b_cmd_addr_q.push_back(b_cmd_byte_addr);
    end

    task automatic step();
        @(negedge clk0);
        #1;
    endtask

    task automatic wait_busy(input int bound, output int n);
        n = 0;
        do begin step(); n++; end while (busy !== 1'b1 && n < bound);
    endtask

    task automatic wait_ready(input bit use_b, input int bound, output int n);
        n = 0;
        do begin step(); n++; end
        while ((use_b ? b_mem_ready : mem_ready) !== 1'b1 && n < bound);
    endtask

    task automatic wait_wr(input int target, input int bound);
        int n = 0;
        while (wr_total < target && n < bound) begin step(); n++; end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0; pll_lock = 1'b1; calib_done = 1'b0;
        repeat (3) step();
        checks++; if (cmd_en !== 1'b0)     begin fails++; $display("FAIL rst_cmd_en got %b want 0", cmd_en); end
        checks++; if (wr_en !== 1'b0)      begin fails++; $display("FAIL rst_wr_en got %b want 0", wr_en); end
        checks++; if (busy !== 1'b0)       begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (mem_ready !== 1'b0)  begin fails++; $display("FAIL rst_mem_ready got %b want 0", mem_ready); end
        checks++; if (error !== 1'b0)      begin fails++; $display("FAIL rst_error got %b want 0", error); end
        checks++; if (cmd_byte_addr !== 30'h0) begin fails++; $display("FAIL rst_addr got %h want 0", cmd_byte_addr); end
        checks++; if (b_cmd_byte_addr !== 30'h1000) begin fails++; $display("FAIL rst_addr_b got %h want 1000", b_cmd_byte_addr); end
        checks++; if (cmd_bl !== 6'd31)    begin fails++; $display("FAIL rst_cmd_bl got %0d want 31", cmd_bl); end
        checks++; if (cmd_instr !== 3'b000) begin fails++; $display("FAIL rst_instr got %0d want 0", cmd_instr); end
        checks++; if (wr_data !== 32'h0)   begin fails++; $display("FAIL rst_wr_data got %h want 0", wr_data); end
        checks++; if (wr_mask !== 4'h0)    begin fails++; $display("FAIL rst_wr_mask got %h want 0", wr_mask); end
        sys_rst_n = 1'b1;
        repeat (100) step();
        checks++; if (busy !== 1'b0 || wr_total !== 0 || cmd_addr_q.size() !== 0) begin
            fails++; $display("FAIL no_cal_idle busy %b pushes %0d cmds %0d want 0/0/0", busy, wr_total, cmd_addr_q.size());
        end
    endtask

    task automatic test_basic_clear();
        int n, bw, bc;
        bw = wr_total; bc = cmd_addr_q.size();
        calib_done = 1'b1;
        // One edge to notice calibration, then 16 settle edges.
        wait_busy(100, n);
        checks++; if (n !== 17) begin fails++; $display("FAIL settle_latency got %0d want 17", n); end
        // Two bursts of 32 pushes plus one command cycle each.
        wait_ready(1'b0, 500, n);
        checks++; if (n !== 66) begin fails++; $display("FAIL clear_latency got %0d want 66", n); end
        checks++; if (wr_total - bw !== 64) begin fails++; $display("FAIL basic_pushes got %0d want 64", wr_total - bw); end
        checks++; if (cmd_addr_q.size() - bc !== 2) begin fails++; $display("FAIL basic_cmds got %0d want 2", cmd_addr_q.size() - bc); end
        if (cmd_addr_q.size() >= bc + 2) begin
            checks++; if (cmd_addr_q[bc] !== 30'h0)    begin fails++; $display("FAIL basic_addr0 got %h want 0", cmd_addr_q[bc]); end
            checks++; if (cmd_addr_q[bc+1] !== 30'h80) begin fails++; $display("FAIL basic_addr1 got %h want 80", cmd_addr_q[bc+1]); end
            checks++; if (cmd_wr_q[bc] - bw !== 32)    begin fails++; $display("FAIL basic_burst0 got %0d want 32", cmd_wr_q[bc] - bw); end
        end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_done got %b want 0", busy); end
        repeat (10) step();
        checks++; if (mem_ready !== 1'b1 || wr_total - bw !== 64) begin
            fails++; $display("FAIL basic_hold ready %b pushes %0d want 1/64", mem_ready, wr_total - bw);
        end
        checks++; if (data_bad !== 0 || cmd_bad !== 0 || mask_bad !== 0) begin
            fails++; $display("FAIL basic_fields data %0d cmd %0d mask %0d want 0", data_bad, cmd_bad, mask_bad);
        end
    endtask

    task automatic test_backpressure();
        int i, bw, bc;
        bw = wr_total; bc = cmd_addr_q.size();
        start = 1'b1; step(); start = 1'b0;
        checks++; if (mem_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_fall got %b want 0", mem_ready); end
        i = 0;
        while (mem_ready !== 1'b1 && i < 3000) begin
            wr_full  = 1'($urandom_range(0, 1));
            cmd_full = (i % 6 != 5);
            step(); i++;
        end
        wr_full = 1'b0; cmd_full = 1'b0;
        checks++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL bp_timeout ready %b want 1", mem_ready); end
        checks++; if (wr_total - bw !== 64) begin fails++; $display("FAIL bp_pushes got %0d want 64", wr_total - bw); end
        checks++; if (cmd_addr_q.size() - bc !== 2) begin fails++; $display("FAIL bp_cmds got %0d want 2", cmd_addr_q.size() - bc); end
        if (cmd_addr_q.size() >= bc + 2) begin
            checks++; if (cmd_wr_q[bc] - bw !== 32) begin fails++; $display("FAIL bp_burst0 got %0d want 32", cmd_wr_q[bc] - bw); end
            checks++; if (cmd_addr_q[bc] !== 30'h0 || cmd_addr_q[bc+1] !== 30'h80) begin
                fails++; $display("FAIL bp_addrs got %h %h want 0 80", cmd_addr_q[bc], cmd_addr_q[bc+1]);
            end
        end
        checks++; if (wrfull_viol !== 0) begin fails++; $display("FAIL bp_wr_full_push got %0d want 0", wrfull_viol); end
        checks++; if (cmdfull_viol !== 0) begin fails++; $display("FAIL bp_cmd_full_cmd got %0d want 0", cmdfull_viol); end
    endtask

    task automatic test_abort();
        int n, bw, bc;
        bw = wr_total; bc = cmd_addr_q.size();
        start = 1'b1; step(); start = 1'b0;
        wait_wr(bw + 40, 200);
        calib_done = 1'b0;
        step();
        checks++; if (wr_en !== 1'b0 || busy !== 1'b0 || cmd_en !== 1'b0) begin
            fails++; $display("FAIL abort_outputs wr_en %b busy %b cmd_en %b want 0/0/0", wr_en, busy, cmd_en);
        end
        checks++; if (cmd_addr_q.size() - bc !== 1) begin fails++; $display("FAIL abort_cmds got %0d want 1", cmd_addr_q.size() - bc); end
        repeat (4) step();
        bw = wr_total; bc = cmd_addr_q.size();
        calib_done = 1'b1;
        wait_busy(100, n);
        checks++; if (n !== 17) begin fails++; $display("FAIL abort_resettle got %0d want 17", n); end
        wait_ready(1'b0, 300, n);
        checks++; if (wr_total - bw !== 64 || cmd_addr_q.size() - bc !== 2) begin
            fails++; $display("FAIL abort_rerun pushes %0d cmds %0d want 64/2", wr_total - bw, cmd_addr_q.size() - bc);
        end
        if (cmd_addr_q.size() >= bc + 2) begin
            checks++; if (cmd_addr_q[bc] !== 30'h0 || cmd_addr_q[bc+1] !== 30'h80) begin
                fails++; $display("FAIL abort_addrs got %h %h want 0 80", cmd_addr_q[bc], cmd_addr_q[bc+1]);
            end
        end
    endtask

    task automatic test_error();
        int n, bw, bc;
        bw = wr_total; bc = cmd_addr_q.size();
        cmd_full = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        wait_wr(bw + 32, 200);
        wr_error = 1'b1; step(); wr_error = 1'b0;
        checks++; if (error !== 1'b1 || busy !== 1'b0 || mem_ready !== 1'b0) begin
            fails++; $display("FAIL err_flags error %b busy %b ready %b want 1/0/0", error, busy, mem_ready);
        end
        cmd_full = 1'b0;
        repeat (20) step();
        checks++; if (cmd_addr_q.size() - bc !== 0 || wr_total - bw !== 32) begin
            fails++; $display("FAIL err_quiet cmds %0d pushes %0d want 0/32", cmd_addr_q.size() - bc, wr_total - bw);
        end
        checks++; if (error !== 1'b1) begin fails++; $display("FAIL err_sticky got %b want 1", error); end
        start = 1'b1; step(); start = 1'b0;
        checks++; if (error !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL err_restart error %b busy %b want 0/1", error, busy);
        end
        wait_ready(1'b0, 300, n);
        checks++; if (mem_ready !== 1'b1 || cmd_addr_q.size() - bc !== 2 || wr_total - bw !== 96) begin
            fails++; $display("FAIL err_rerun ready %b cmds %0d pushes %0d want 1/2/96", mem_ready, cmd_addr_q.size() - bc, wr_total - bw);
        end
        if (cmd_addr_q.size() >= bc + 2) begin
            checks++; if (cmd_addr_q[bc] !== 30'h0 || cmd_addr_q[bc+1] !== 30'h80) begin
                fails++; $display("FAIL err_addrs got %h %h want 0 80", cmd_addr_q[bc], cmd_addr_q[bc+1]);
            end
        end
    endtask

    task automatic test_underrun();
        int n, bw;
        bw = wr_total;
        start = 1'b1; step(); start = 1'b0;
        wait_wr(bw + 5, 100);
        wr_underrun = 1'b1; step(); wr_underrun = 1'b0;
        checks++; if (error !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL underrun_flags error %b busy %b want 1/0", error, busy);
        end
        start = 1'b1; step(); start = 1'b0;
        wait_ready(1'b0, 300, n);
        checks++; if (mem_ready !== 1'b1 || error !== 1'b0) begin
            fails++; $display("FAIL underrun_recover ready %b error %b want 1/0", mem_ready, error);
        end
    endtask

    task automatic test_restart_base();
        int n, bw, bc;
        bw = b_wr_total; bc = b_cmd_addr_q.size();
        start = 1'b1; step(); start = 1'b0;
        checks++; if (b_mem_ready !== 1'b0 || b_busy !== 1'b1) begin
            fails++; $display("FAIL base_start ready %b busy %b want 0/1", b_mem_ready, b_busy);
        end
        wait_ready(1'b1, 300, n);
        checks++; if (b_mem_ready !== 1'b1 || b_wr_total - bw !== 64) begin
            fails++; $display("FAIL base_done ready %b pushes %0d want 1/64", b_mem_ready, b_wr_total - bw);
        end
        checks++; if (b_cmd_addr_q.size() - bc !== 2) begin fails++; $display("FAIL base_cmds got %0d want 2", b_cmd_addr_q.size() - bc); end
        if (b_cmd_addr_q.size() >= bc + 2) begin
            checks++; if (b_cmd_addr_q[bc] !== 30'h1000 || b_cmd_addr_q[bc+1] !== 30'h1080) begin
                fails++; $display("FAIL base_addrs got %h %h want 1000 1080", b_cmd_addr_q[bc], b_cmd_addr_q[bc+1]);
            end
        end
        checks++; if (b_data_bad !== 0) begin fails++; $display("FAIL base_pattern got %0d bad words want 0", b_data_bad); end
    endtask

    task automatic test_start_ignored();
        int n, bw, bc;
        calib_done = 1'b0; step();
        checks++; if (mem_ready !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL ign_abort_done ready %b busy %b want 0/0", mem_ready, busy);
        end
        repeat (3) step();
        calib_done = 1'b1;
        n = 0;
        do begin step(); n++; start = (n == 5); end while (busy !== 1'b1 && n < 100);
        start = 1'b0;
        checks++; if (n !== 17) begin fails++; $display("FAIL ign_settle got %0d want 17", n); end
        bw = wr_total; bc = cmd_addr_q.size();
        n = 0;
        do begin step(); n++; start = (wr_total - bw == 10); end while (mem_ready !== 1'b1 && n < 500);
        start = 1'b0;
        checks++; if (n !== 66) begin fails++; $display("FAIL ign_fill_latency got %0d want 66", n); end
        checks++; if (wr_total - bw !== 64 || cmd_addr_q.size() - bc !== 2) begin
            fails++; $display("FAIL ign_counts pushes %0d cmds %0d want 64/2", wr_total - bw, cmd_addr_q.size() - bc);
        end
        if (cmd_addr_q.size() >= bc + 2) begin
            checks++; if (cmd_addr_q[bc] !== 30'h0 || cmd_addr_q[bc+1] !== 30'h80) begin
                fails++; $display("FAIL ign_addrs got %h %h want 0 80", cmd_addr_q[bc], cmd_addr_q[bc+1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_clear();
        test_backpressure();
        test_abort();
        test_error();
        test_underrun();
        test_restart_base();
        test_start_ignored();
        checks++; if (data_bad !== 0 || mask_bad !== 0 || cmd_bad !== 0) begin
            fails++; $display("FAIL final_fields data %0d mask %0d cmd %0d want 0", data_bad, mask_bad, cmd_bad);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
